icache_dm: RTL and testbench

//  Direct-mapped instruction cache in the IF stage; the source of stallreq_from_ic to ctrl.
//  On a hit it returns the instruction combinationally; on a miss it raises stallreq_o.

---
 rtl/icache_dm.sv | 123 ++++++++++++
 tb/tb_icache_dm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-serial line refill; stalls IF on a miss.
// Define ICACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics counters.
module icache_dm #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        inv_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int WORDS = 2 ** (INDEX_W + OFFSET_W);
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL
    } state_t;

    state_t                      state;
    logic [LINES-1:0]            valid_q;
    logic [TAG_W-1:0]            tag_q  [LINES];
    logic [31:0]                 data_q [WORDS];
    logic [TAG_W+INDEX_W-1:0]    base_q;
    logic [OFFSET_W-1:0]         beat_q;
    logic                        drop_q;

    logic [OFFSET_W-1:0]         pc_off;
    logic [INDEX_W-1:0]          pc_idx;
    logic [TAG_W-1:0]            pc_tag;
    logic [INDEX_W-1:0]          base_idx;
    logic [TAG_W-1:0]            base_tag;
    logic                        hit;
    logic                        unused_pc_bits;

    assign pc_off         = pc_i[OFFSET_W+1:2];
    assign pc_idx         = pc_i[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign pc_tag         = pc_i[31:OFFSET_W+INDEX_W+2];
    assign unused_pc_bits = ^pc_i[1:0];
    assign base_idx       = base_q[INDEX_W-1:0];
    assign base_tag       = base_q[TAG_W+INDEX_W-1:INDEX_W];

    assign hit        = ce_i & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign inst_o     = ce_i ? data_q[{pc_idx, pc_off}] : 32'h0;
    assign stallreq_o = (state == IDLE) ? (ce_i & ~hit) : 1'b1;
    assign mem_req_o  = (state == REFILL);
    assign mem_addr_o = (state == REFILL) ? {base_q, beat_q, 2'b00} : 32'h0;

    // Control FSM; an invalidate during REFILL poisons the line being fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_i) valid_q <= '0;
                    if (ce_i && !hit) begin
                        base_q <= {pc_tag, pc_idx};
                        beat_q <= '0;
                        drop_q <= 1'b0;
                        state  <= REFILL;
                    end
                end
                REFILL: begin
                    if (inv_i) begin
                        valid_q <= '0;
                        drop_q  <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == '1) state <= FILL;
                    end
                end
                FILL: begin
                    if (inv_i) valid_q <= '0;
                    else       valid_q[base_idx] <= ~drop_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays need no reset: valid_q alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (!rst && state == REFILL && mem_ack_i)
            data_q[{base_idx, beat_q}] <= mem_rdata_i;
        if (!rst && state == FILL)
            tag_q[base_idx] <= base_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == IDLE) begin
            if (hit)        hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (ce_i && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios then random fetches against a line-level model.
// Build with ICACHE_STATS_EN defined to also check the statistics counters.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic        inv_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
    logic [31:0] exp_hits   = 0;
    logic [31:0] exp_misses = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Cache contents as seen from outside: which tag each line holds, if any.
    bit          mv [64];
    logic [21:0] mt [64];

    always #5 clk = ~clk;

    icache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .pc_i        (pc_i),
        .inv_i       (inv_i),
        .inst_o      (inst_o),
        .stallreq_o  (stallreq_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ce, input logic [31:0] pc, input logic inv,
                                 input logic ack, input logic [31:0] rdata);
        ce_i        = ce;
        pc_i        = pc;
        inv_i       = inv;
        mem_ack_i   = ack;
        mem_rdata_i = rdata;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    // One complete fetch of pc: a single hit cycle, or a miss with its whole refill.
    task automatic fetch(input logic [31:0] pc, input int gap, input int inv_beat,
                         input bit inv_fill, input bit ce_drop);
        int          idx;
        logic [21:0] tag;
        logic [31:0] base;
        bit          drop;
        bit          inv;
        bit          ack;
        logic        ce;
        idx  = int'(pc[9:4]);
        tag  = pc[31:10];
        base = {pc[31:4], 4'h0};
        if (mv[idx] && mt[idx] == tag) begin
            applyStimulus(1'b1, pc, 1'b0, 1'($urandom_range(0, 1)), $urandom);
            checkOutput("hit_stall", {31'b0, stallreq_o}, 32'd0);
            checkOutput("hit_req", {31'b0, mem_req_o}, 32'd0);
            checkOutput("hit_inst", inst_o, mem_word(pc));
`ifdef ICACHE_STATS_EN
            exp_hits++;
`endif
            cycle();
            return;
        end
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 32'h0);
        checkOutput("miss_stall", {31'b0, stallreq_o}, 32'd1);
        checkOutput("miss_req", {31'b0, mem_req_o}, 32'd0);
`ifdef ICACHE_STATS_EN
        exp_misses++;
`endif
        cycle();
        drop = 1'b0;
        for (int beat = 0; beat < 4; beat++) begin
            for (int w = 0; w <= gap; w++) begin
                inv = (beat == inv_beat) && (w == 0);
                ack = (w == gap);
                ce  = ce_drop ? 1'($urandom_range(0, 1)) : 1'b1;
                applyStimulus(ce, pc, inv, ack, ack ? mem_word(base + 32'(beat * 4)) : $urandom);
                checkOutput("refill_stall", {31'b0, stallreq_o}, 32'd1);
                checkOutput("refill_req", {31'b0, mem_req_o}, 32'd1);
                checkOutput("refill_addr", mem_addr_o, base + 32'(beat * 4));
                if (!ce) checkOutput("ce_low_inst", inst_o, 32'h0);
                if (inv) begin
                    drop = 1'b1;
                    clearModel();
                end
                cycle();
            end
        end
        applyStimulus(ce_drop ? 1'($urandom_range(0, 1)) : 1'b1, pc, inv_fill,
                      1'($urandom_range(0, 1)), $urandom);
        checkOutput("fill_stall", {31'b0, stallreq_o}, 32'd1);
        checkOutput("fill_req", {31'b0, mem_req_o}, 32'd0);
        cycle();
        mt[idx] = tag;
        if (inv_fill) clearModel();
        else          mv[idx] = !drop;
    endtask

    // Reset lands after two acks of a refill; the line must not survive.
    task automatic resetMidRefill(input logic [31:0] pc);
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 32'h0);
        checkOutput("rmr_stall", {31'b0, stallreq_o}, 32'd1);
        cycle();
        for (int beat = 0; beat < 2; beat++) begin
            applyStimulus(1'b1, pc, 1'b0, 1'b1, mem_word(base + 32'(beat * 4)));
            checkOutput("rmr_addr", mem_addr_o, base + 32'(beat * 4));
            cycle();
        end
        rst = 1'b1;
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 32'h0);
        cycle();
        rst = 1'b0;
        clearModel();
`ifdef ICACHE_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
        #1;
        checkOutput("rmr_miss_cnt", miss_cnt_o, 32'd0);
        checkOutput("rmr_hit_cnt", hit_cnt_o, 32'd0);
`endif
        fetch(pc, 0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        clearModel();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_stall", {31'b0, stallreq_o}, 32'd0);
        checkOutput("rst_req", {31'b0, mem_req_o}, 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_inst_ce0", inst_o, 32'h0);
        cycle();

        fetch(32'h100, 0, -1, 1'b0, 1'b0);
        fetch(32'h100, 0, -1, 1'b0, 1'b0);
        fetch(32'h104, 0, -1, 1'b0, 1'b0);
        fetch(32'h108, 0, -1, 1'b0, 1'b0);
        fetch(32'h10C, 0, -1, 1'b0, 1'b0);

        fetch(32'h500, 0, -1, 1'b0, 1'b0);
        fetch(32'h504, 0, -1, 1'b0, 1'b0);
        fetch(32'h100, 0, -1, 1'b0, 1'b0);

        fetch(32'h240, 2, -1, 1'b0, 1'b0);
        fetch(32'h24C, 0, -1, 1'b0, 1'b0);

        fetch(32'h200, 0, 1, 1'b0, 1'b0);
        fetch(32'h200, 0, -1, 1'b0, 1'b0);
        fetch(32'h100, 0, -1, 1'b0, 1'b0);

        applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 32'h0);
        checkOutput("idle_inv_stall", {31'b0, stallreq_o}, 32'd0);
        cycle();
        clearModel();
        fetch(32'h100, 0, -1, 1'b0, 1'b0);

        fetch(32'h700, 0, -1, 1'b1, 1'b0);
        fetch(32'h700, 0, -1, 1'b0, 1'b0);

        fetch(32'h808, 1, -1, 1'b0, 1'b1);
        fetch(32'h80C, 0, -1, 1'b0, 1'b0);

        resetMidRefill(32'h300);
        fetch(32'h304, 0, -1, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] pc;
            logic [5:0]  idx;
            int          inv_beat;
            bit          inv;
            case ($urandom_range(0, 3))
                0:       idx = 6'h10;
                1:       idx = 6'h20;
                2:       idx = 6'h3F;
                default: idx = 6'($urandom);
            endcase
            pc = {22'($urandom_range(0, 3)), idx, 2'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) begin
                inv = 1'($urandom_range(0, 1));
                applyStimulus(1'b0, pc, inv, 1'($urandom_range(0, 1)), $urandom);
                checkOutput("rnd_ce0_stall", {31'b0, stallreq_o}, 32'd0);
                checkOutput("rnd_ce0_inst", inst_o, 32'h0);
                checkOutput("rnd_ce0_req", {31'b0, mem_req_o}, 32'd0);
                cycle();
                if (inv) clearModel();
            end
            inv_beat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(pc, int'($urandom_range(0, 2)), inv_beat,
                  $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));
        end

`ifdef ICACHE_STATS_EN
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("stats_hits", hit_cnt_o, exp_hits);
        checkOutput("stats_misses", miss_cnt_o, exp_misses);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
